// File: rtl/adc_frame_packer.sv
// adc_frame_packer: registers the ADC bus, decimates it, and packs PACK samples
// per word into the 40-bit FIFO write port, with frame start/stop control,
// zero-padded flush of a partial word, and a saturating afull drop counter.
module adc_frame_packer #(
  parameter int unsigned SAMPLE_W = 10,
  parameter int unsigned PACK     = 4,
  parameter int unsigned DECIM_W  = 8,
  parameter int unsigned LEN_W    = 16
) (
  input  logic                       clk50,
  input  logic                       reset,
  input  logic [SAMPLE_W-1:0]        adpin,
  input  logic                       adcovr,
  input  logic                       start,
  input  logic                       stop,
  input  logic [DECIM_W-1:0]         decim,
  input  logic [LEN_W-1:0]           frame_len,
  input  logic                       afull,
  output logic [SAMPLE_W*PACK-1:0]   odata,
  output logic                       wren,
  output logic                       busy,
  output logic                       ovr_flag,
  output logic [15:0]                drop_cnt
);

  localparam int unsigned IDX_W = (PACK > 1) ? $clog2(PACK) : 1;

  typedef enum logic [1:0] {IDLE, CAPTURE, FLUSH} state_t;

  state_t                    state, state_nxt;
  logic [SAMPLE_W-1:0]       s1_data;
  logic                      s1_ovr;
  logic [SAMPLE_W-1:0]       slot_q [PACK];
  logic [IDX_W-1:0]          idx;
  logic [DECIM_W-1:0]        dcnt;
  logic [DECIM_W-1:0]        decim_q;
  logic [LEN_W-1:0]          flen_q;
  logic [LEN_W-1:0]          word_cnt;
  logic                      complete_q;
  logic                      last_slot;
  logic                      accept;
  logic                      emit;
  logic                      frame_done;
  logic [SAMPLE_W*PACK-1:0]  word;

  // Acceptance, emission and end-of-frame decisions from S1 and current state.
  // A stop arriving on the sample that fills the last slot still takes that
  // sample, so the completed word goes out whole instead of being flushed short.
  always_comb begin
    last_slot  = (idx == IDX_W'(PACK - 1));
    accept     = (state == CAPTURE) && (dcnt == '0) && (!stop || last_slot);
    emit       = complete_q || (state == FLUSH);
    frame_done = complete_q && (flen_q != '0) && ((word_cnt + LEN_W'(1)) == flen_q);
  end

  // Output word: all slots for a completed word, unfilled slots zeroed in FLUSH.
  always_comb begin
    word = '0;
    for (int unsigned i = 0; i < PACK; i++) begin
      if ((state != FLUSH) || (IDX_W'(i) < idx))
        word[i*SAMPLE_W +: SAMPLE_W] = slot_q[i];
    end
  end

  // Next-state logic for the frame controller.
  always_comb begin
    state_nxt = state;
    busy      = (state != IDLE);
    case (state)
      IDLE:    if (start) state_nxt = CAPTURE;
      CAPTURE: begin
        if (frame_done)
          state_nxt = IDLE;
        else if (stop)
          state_nxt = ((idx == '0) || accept) ? IDLE : FLUSH;
      end
      FLUSH:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Input stage, packing registers, counters and FIFO write port.
  always_ff @(posedge clk50) begin
    if (reset) begin
      state      <= IDLE;
      s1_data    <= '0;
      s1_ovr     <= 1'b0;
      for (int unsigned i = 0; i < PACK; i++) slot_q[i] <= '0;
      idx        <= '0;
      dcnt       <= '0;
      decim_q    <= '0;
      flen_q     <= '0;
      word_cnt   <= '0;
      complete_q <= 1'b0;
      odata      <= '0;
      wren       <= 1'b0;
      ovr_flag   <= 1'b0;
      drop_cnt   <= '0;
    end else begin
      s1_data    <= adpin;
      s1_ovr     <= adcovr;
      state      <= state_nxt;
      wren       <= 1'b0;
      complete_q <= accept && last_slot;

      if (state == CAPTURE)
        dcnt <= (dcnt == decim_q) ? '0 : dcnt + 1'b1;

      if (accept) begin
        slot_q[idx] <= s1_data;
        idx         <= last_slot ? '0 : idx + 1'b1;
        if (s1_ovr) ovr_flag <= 1'b1;
      end

      if (state == FLUSH)
        idx <= '0;

      if (emit) begin
        word_cnt <= word_cnt + 1'b1;
        if (!afull) begin
          odata <= word;
          wren  <= 1'b1;
        end else if (drop_cnt != '1) begin
          drop_cnt <= drop_cnt + 1'b1;
        end
      end

      if ((state == IDLE) && start) begin
        decim_q    <= decim;
        flen_q     <= frame_len;
        ovr_flag   <= 1'b0;
        drop_cnt   <= '0;
        idx        <= '0;
        dcnt       <= '0;
        word_cnt   <= '0;
        complete_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_adc_frame_packer.sv
// Directed bench for adc_frame_packer: fixed ramps with hand-computed words
// and write cycles, one task per scenario.
module tb_adc_frame_packer;

  logic        clk50;
  logic        reset;
  logic [9:0]  adpin;
  logic        adcovr;
  logic        start;
  logic        stop;
  logic [7:0]  decim;
  logic [15:0] frame_len;
  logic        afull;
  logic [39:0] odata;
  logic        wren;
  logic        busy;
  logic        ovr_flag;
  logic [15:0] drop_cnt;

  int checks;
  int failures;
  int cyc;
  logic [39:0] wq_data [$];
  int          wq_cyc  [$];
  logic        wq_busy [$];

  adc_frame_packer #(.SAMPLE_W(10), .PACK(4), .DECIM_W(8), .LEN_W(16)) dut (
    .clk50(clk50), .reset(reset), .adpin(adpin), .adcovr(adcovr),
    .start(start), .stop(stop), .decim(decim), .frame_len(frame_len),
    .afull(afull), .odata(odata), .wren(wren), .busy(busy),
    .ovr_flag(ovr_flag), .drop_cnt(drop_cnt)
  );

  initial clk50 = 1'b0;
  always #5 clk50 = ~clk50;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // One clock: drive at negedge, sample 1 time unit after the rising edge.
  task automatic step(input logic [9:0] a, input logic ov, input logic st,
                      input logic sp, input logic af);
    @(negedge clk50);
    adpin = a; adcovr = ov; start = st; stop = sp; afull = af;
    @(posedge clk50);
    #1;
    cyc++;
    if (wren) begin
      wq_data.push_back(odata);
      wq_cyc.push_back(cyc);
      wq_busy.push_back(busy);
    end
  endtask

  task automatic clear_q();
    wq_data.delete(); wq_cyc.delete(); wq_busy.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(10'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(10'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    clear_q();
  endtask

  task automatic test_reset();
    decim = '0; frame_len = '0;
    do_reset();
    checks++; if (wren !== 1'b0) begin failures++; $display("FAIL reset_wren got=%b exp=0", wren); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (odata !== 40'h0) begin failures++; $display("FAIL reset_odata got=%h exp=0", odata); end
    checks++; if (ovr_flag !== 1'b0) begin failures++; $display("FAIL reset_ovr got=%b exp=0", ovr_flag); end
    checks++; if (drop_cnt !== 16'h0) begin failures++; $display("FAIL reset_drop got=%h exp=0", drop_cnt); end
  endtask

  task automatic test_ramp_len2();
    int s;
    do_reset();
    decim = 8'd0; frame_len = 16'd2;
    step(10'd1, 1'b0, 1'b1, 1'b0, 1'b0);
    s = cyc;
    for (int k = 2; k <= 14; k++) step(10'(k), 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (wq_data.size() !== 2) begin
      failures++; $display("FAIL len2_count got=%0d exp=2", wq_data.size());
    end else begin
      checks++; if (wq_cyc[0] !== s + 5) begin failures++; $display("FAIL len2_w0_cycle got=%0d exp=%0d", wq_cyc[0] - s, 5); end
      checks++; if (wq_data[0] !== 40'h01_0030_0801) begin failures++; $display("FAIL len2_w0_data got=%h exp=0100300801", wq_data[0]); end
      checks++; if (wq_cyc[1] !== s + 9) begin failures++; $display("FAIL len2_w1_cycle got=%0d exp=%0d", wq_cyc[1] - s, 9); end
      checks++; if (wq_data[1] !== 40'h02_0070_1805) begin failures++; $display("FAIL len2_w1_data got=%h exp=0200701805", wq_data[1]); end
      checks++; if (wq_busy[0] !== 1'b1) begin failures++; $display("FAIL len2_busy_mid got=%b exp=1", wq_busy[0]); end
      checks++; if (wq_busy[1] !== 1'b0) begin failures++; $display("FAIL len2_busy_end got=%b exp=0", wq_busy[1]); end
    end
  endtask

  task automatic test_decim();
    int s;
    do_reset();
    decim = 8'd2; frame_len = 16'd1;
    step(10'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    s = cyc;
    for (int k = 1; k <= 20; k++) begin
      if (k == 5) decim = 8'd0;
      step(10'(k), 1'b0, (k == 5), 1'b0, 1'b0);
    end
    checks++;
    if (wq_data.size() !== 1) begin
      failures++; $display("FAIL decim_count got=%0d exp=1", wq_data.size());
    end else begin
      checks++; if (wq_cyc[0] !== s + 11) begin failures++; $display("FAIL decim_cycle got=%0d exp=11", wq_cyc[0] - s); end
      checks++; if (wq_data[0] !== 40'h02_4060_0C00) begin failures++; $display("FAIL decim_data got=%h exp=0240600c00", wq_data[0]); end
    end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL decim_busy_end got=%b exp=0", busy); end
  endtask

  task automatic test_stop_flush();
    int s;
    do_reset();
    decim = 8'd0; frame_len = 16'd0;
    step(10'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    s = cyc;
    for (int k = 1; k <= 12; k++) begin
      step(10'(k), 1'b0, 1'b0, (k == 7), 1'b0);
      if (k == 7) begin
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL flush_busy got=%b exp=1", busy); end
      end
    end
    checks++;
    if (wq_data.size() !== 2) begin
      failures++; $display("FAIL flush_count got=%0d exp=2", wq_data.size());
    end else begin
      checks++; if (wq_cyc[0] !== s + 5) begin failures++; $display("FAIL flush_w0_cycle got=%0d exp=5", wq_cyc[0] - s); end
      checks++; if (wq_data[0] !== 40'h00_C020_0400) begin failures++; $display("FAIL flush_w0_data got=%h exp=00c0200400", wq_data[0]); end
      checks++; if (wq_cyc[1] !== s + 8) begin failures++; $display("FAIL flush_pad_cycle got=%0d exp=8", wq_cyc[1] - s); end
      checks++; if (wq_data[1] !== 40'h00_0000_1404) begin failures++; $display("FAIL flush_pad_data got=%h exp=0000001404", wq_data[1]); end
      checks++; if (wq_busy[1] !== 1'b0) begin failures++; $display("FAIL flush_busy_end got=%b exp=0", wq_busy[1]); end
    end
  endtask

  task automatic test_afull_drop();
    int s;
    do_reset();
    decim = 8'd0; frame_len = 16'd0;
    step(10'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    s = cyc;
    for (int k = 1; k <= 20; k++) step(10'(k), 1'b0, 1'b0, 1'b0, (k <= 13));
    checks++; if (drop_cnt !== 16'd3) begin failures++; $display("FAIL afull_drop_cnt got=%0d exp=3", drop_cnt); end
    checks++;
    if (wq_data.size() !== 1) begin
      failures++; $display("FAIL afull_count got=%0d exp=1", wq_data.size());
    end else begin
      checks++; if (wq_cyc[0] !== s + 17) begin failures++; $display("FAIL afull_cycle got=%0d exp=17", wq_cyc[0] - s); end
      checks++; if (wq_data[0] !== 40'h03_C0E0_340C) begin failures++; $display("FAIL afull_data got=%h exp=03c0e0340c", wq_data[0]); end
    end
  endtask

  task automatic test_overrange();
    int s;
    do_reset();
    decim = 8'd1; frame_len = 16'd1;
    step(10'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    s = cyc;
    for (int k = 1; k <= 12; k++) begin
      step(10'(k), (k == 1) || (k == 4), 1'b0, 1'b0, 1'b0);
      if (k == 3) begin
        checks++; if (ovr_flag !== 1'b0) begin failures++; $display("FAIL ovr_skipped got=%b exp=0", ovr_flag); end
      end
      if (k == 5) begin
        checks++; if (ovr_flag !== 1'b1) begin failures++; $display("FAIL ovr_accepted got=%b exp=1", ovr_flag); end
      end
    end
    checks++; if (ovr_flag !== 1'b1) begin failures++; $display("FAIL ovr_sticky got=%b exp=1", ovr_flag); end
    checks++;
    if (wq_data.size() !== 1) begin
      failures++; $display("FAIL ovr_count got=%0d exp=1", wq_data.size());
    end else begin
      checks++; if (wq_cyc[0] !== s + 8) begin failures++; $display("FAIL ovr_cycle got=%0d exp=8", wq_cyc[0] - s); end
      checks++; if (wq_data[0] !== 40'h01_8040_0800) begin failures++; $display("FAIL ovr_data got=%h exp=0180400800", wq_data[0]); end
    end
    decim = 8'd0;
    step(10'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    checks++; if (ovr_flag !== 1'b0) begin failures++; $display("FAIL ovr_cleared got=%b exp=0", ovr_flag); end
  endtask

  task automatic test_reset_midframe();
    int s;
    do_reset();
    decim = 8'd0; frame_len = 16'd2;
    step(10'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 6; k++) step(10'(k), 1'b0, 1'b0, 1'b0, 1'b0);
    checks++; if (odata !== 40'h00_C020_0400) begin failures++; $display("FAIL mid_pre_odata got=%h exp=00c0200400", odata); end
    reset = 1'b1;
    step(10'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    clear_q();
    checks++; if (wren !== 1'b0) begin failures++; $display("FAIL mid_wren got=%b exp=0", wren); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mid_busy got=%b exp=0", busy); end
    checks++; if (odata !== 40'h0) begin failures++; $display("FAIL mid_odata got=%h exp=0", odata); end
    step(10'd8, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 6; k++) step(10'(9 + k), 1'b0, 1'b0, 1'b0, 1'b0);
    checks++; if (wq_data.size() !== 0) begin failures++; $display("FAIL idle_stop_wren got=%0d exp=0", wq_data.size()); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL idle_stop_busy got=%b exp=0", busy); end
    frame_len = 16'd1;
    step(10'd20, 1'b0, 1'b1, 1'b0, 1'b0);
    s = cyc;
    for (int k = 21; k <= 30; k++) step(10'(k), 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (wq_data.size() !== 1) begin
      failures++; $display("FAIL fresh_count got=%0d exp=1", wq_data.size());
    end else begin
      checks++; if (wq_cyc[0] !== s + 5) begin failures++; $display("FAIL fresh_cycle got=%0d exp=5", wq_cyc[0] - s); end
      checks++; if (wq_data[0] !== 40'h05_C160_5414) begin failures++; $display("FAIL fresh_data got=%h exp=05c1605414", wq_data[0]); end
    end
  endtask

  initial begin
    checks = 0; failures = 0; cyc = 0;
    reset = 1'b1; adpin = '0; adcovr = 1'b0; start = 1'b0; stop = 1'b0;
    decim = '0; frame_len = '0; afull = 1'b0;
    test_reset();
    test_ramp_len2();
    test_decim();
    test_stop_flush();
    test_afull_drop();
    test_overrange();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
